// File: rtl/accum_button_ctrl_if.sv
// rtl/accum_button_ctrl_if.sv - button inputs and conditioned strobe/status outputs of accum_button_ctrl
interface accum_button_ctrl_if;
    logic       Run_Accumulate;
    logic       Reset_Clear;
    logic       Run_O;
    logic       Clear_O;
    logic       Run_Held;
    logic [7:0] Run_Count;

    modport master (
        output Run_Accumulate,
        output Reset_Clear,
        input  Run_O,
        input  Clear_O,
        input  Run_Held,
        input  Run_Count
    );

    modport slave (
        input  Run_Accumulate,
        input  Reset_Clear,
        output Run_O,
        output Clear_O,
        output Run_Held,
        output Run_Count
    );
endinterface

// File: rtl/accum_button_ctrl.sv
// rtl/accum_button_ctrl.sv - synchronise, debounce and single-pulse the run/clear buttons, count run presses
module accum_button_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CW              = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    accum_button_ctrl_if.slave btn
);

    localparam logic [1:0] RELEASED     = 2'd0;
    localparam logic [1:0] PRESS_WAIT   = 2'd1;
    localparam logic [1:0] PRESSED      = 2'd2;
    localparam logic [1:0] RELEASE_WAIT = 2'd3;

    localparam logic [CW-1:0] DB_LIMIT = CW'(DEBOUNCE_CYCLES);

    // Channel 0 is run/accumulate, channel 1 is reset/clear; both active-low raw.
    logic [1:0] raw_n;
    logic [1:0] pulse;
    logic [1:0] held;
    logic [7:0] run_count;

    assign raw_n = {btn.Reset_Clear, btn.Run_Accumulate};

    for (genvar g = 0; g < 2; g++) begin : g_ch
        logic          sync1;
        logic          sync2;
        logic [1:0]    state;
        logic [CW-1:0] cnt;
        logic          pulse_q;

        // Two-flop synchroniser; resets to released (high) so reset never looks like a press.
        always_ff @(posedge Clk or posedge Reset) begin
            if (Reset) begin
                sync1 <= 1'b1;
                sync2 <= 1'b1;
            end else begin
                sync1 <= raw_n[g];
                sync2 <= sync1;
            end
        end

        // Debounce FSM; the pulse fires only on the qualified PRESS_WAIT->PRESSED transition.
        always_ff @(posedge Clk or posedge Reset) begin
            if (Reset) begin
                state   <= RELEASED;
                cnt     <= '0;
                pulse_q <= 1'b0;
            end else begin
                pulse_q <= 1'b0;
                case (state)
                    RELEASED: begin
                        if (!sync2) begin
                            state <= PRESS_WAIT;
                            cnt   <= CW'(1);
                        end else begin
                            cnt <= '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (sync2) begin
                            state <= RELEASED;
                            cnt   <= '0;
                        end else if (cnt == DB_LIMIT) begin
                            state   <= PRESSED;
                            cnt     <= '0;
                            pulse_q <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    PRESSED: begin
                        if (sync2) begin
                            state <= RELEASE_WAIT;
                            cnt   <= CW'(1);
                        end else begin
                            cnt <= '0;
                        end
                    end
                    RELEASE_WAIT: begin
                        if (!sync2) begin
                            state <= PRESSED;
                            cnt   <= '0;
                        end else if (cnt == DB_LIMIT) begin
                            state <= RELEASED;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: begin
                        state <= RELEASED;
                        cnt   <= '0;
                    end
                endcase
            end
        end

        assign pulse[g] = pulse_q;
        assign held[g]  = (state == PRESSED) || (state == RELEASE_WAIT);
    end

    // Run press counter; a clear pulse overrides a coincident run pulse.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            run_count <= '0;
        end else if (pulse[1]) begin
            run_count <= '0;
        end else if (pulse[0]) begin
            run_count <= run_count + 8'd1;
        end
    end

    assign btn.Run_O     = pulse[0];
    assign btn.Clear_O   = pulse[1];
    assign btn.Run_Held  = held[0];
    assign btn.Run_Count = run_count;

endmodule
